// File: rtl/fetch_unit_if.sv
// Fetch-to-ROM and fetch-to-decode signal bundle plus the execute redirect.
// The master side is the fetch unit; the slave side is the ROM/decode/execute environment.
interface fetch_unit_if;
  logic [15:0] rom_addr;
  logic        BW;
  logic [15:0] rom_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_ext1;
  logic [15:0] out_ext2;
  logic [15:0] out_pc;
  logic [1:0]  out_nwords;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  modport master (
    output rom_addr, BW, out_valid, out_instr, out_ext1, out_ext2, out_pc, out_nwords,
    input  rom_out, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  rom_addr, BW, out_valid, out_instr, out_ext1, out_ext2, out_pc, out_nwords,
    output rom_out, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one ROM word per cycle, bundles of 1-3 words held for decode (2/3/4 cycles min).
// Backpressure: bundle stays in HOLD until out_ready; a redirect discards it and refetches from the target.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {VEC, OP, EXT1, EXT2, HOLD} st_t;

  st_t         st, st_nxt;
  logic [15:0] pc;
  logic [15:0] instr_q, ext1_q, ext2_q, opc_pc_q;
  logic [1:0]  nwords_q;

  // The opcode is decoded straight off the ROM in OP, and from the latched copy in EXT1.
  logic [15:0] dec_op;
  logic        fmt1, fmt2, src_ext, dst_ext, redirect;
  logic [1:0]  as_f;
  logic [3:0]  rs_f;

  assign dec_op   = (st == OP) ? bus.rom_out : instr_q;
  assign fmt1     = dec_op[15:12] >= 4'd4;
  assign fmt2     = dec_op[15:10] == 6'b000100;
  assign as_f     = dec_op[5:4];
  assign rs_f     = fmt1 ? dec_op[11:8] : dec_op[3:0];
  assign src_ext  = (fmt1 || fmt2) &&
                    (((as_f == 2'b01) && (rs_f != 4'd3)) || ((as_f == 2'b11) && (rs_f == 4'd0)));
  assign dst_ext  = fmt1 && dec_op[7];
  assign redirect = bus.redirect_valid && (st != VEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= VEC;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt         = st;
    bus.rom_addr   = pc;
    bus.BW         = 1'b0;
    bus.out_valid  = 1'b0;
    if (redirect) begin
      st_nxt = OP;
    end else begin
      case (st)
        VEC:     st_nxt = OP;
        OP:      st_nxt = (src_ext || dst_ext) ? EXT1 : HOLD;
        EXT1:    st_nxt = (src_ext && dst_ext) ? EXT2 : HOLD;
        EXT2:    st_nxt = HOLD;
        HOLD:    st_nxt = bus.out_ready ? OP : HOLD;
        default: st_nxt = VEC;
      endcase
    end
    if (st == VEC)  bus.rom_addr  = RESET_VECTOR;
    if (st == HOLD) bus.out_valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 16'h0000;
      instr_q  <= 16'h0000;
      ext1_q   <= 16'h0000;
      ext2_q   <= 16'h0000;
      opc_pc_q <= 16'h0000;
      nwords_q <= 2'd0;
    end else if (redirect) begin
      pc <= bus.redirect_pc & 16'hFFFE;
    end else begin
      case (st)
        VEC: pc <= bus.rom_out & 16'hFFFE;
        OP: begin
          instr_q  <= bus.rom_out;
          opc_pc_q <= pc;
          pc       <= pc + 16'd2;
          ext1_q   <= 16'h0000;
          ext2_q   <= 16'h0000;
          nwords_q <= 2'd1 + {1'b0, src_ext} + {1'b0, dst_ext};
        end
        EXT1: begin
          ext1_q <= bus.rom_out;
          pc     <= pc + 16'd2;
        end
        EXT2: begin
          ext2_q <= bus.rom_out;
          pc     <= pc + 16'd2;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_instr  = instr_q;
  assign bus.out_ext1   = ext1_q;
  assign bus.out_ext2   = ext2_q;
  assign bus.out_pc     = opc_pc_q;
  assign bus.out_nwords = nwords_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: ROM model, randomized program/stalls/redirects/resets.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] ext1;
    logic [15:0] ext2;
    logic [15:0] pc;
    logic [1:0]  nw;
  } bundle_t;

  logic clk;
  logic rst_n;
  fetch_unit_if bus();

  logic [15:0] rom [0:65535];
  bundle_t     q[$];
  bundle_t     mon_e;
  logic [15:0] model_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit #(.RESET_VECTOR(16'hFFFE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rom_out = rom[bus.rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_bench();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Bundle length from the instruction-set rules, in plain integer arithmetic.
  function automatic int ref_len(input logic [15:0] op);
    int v, as_v, rs_v, f1, f2, src, dst;
    v    = int'(op);
    f1   = ((v / 4096) >= 4) ? 1 : 0;
    f2   = ((v / 1024) == 4) ? 1 : 0;
    as_v = (v / 16) % 4;
    rs_v = (f1 == 1) ? (v / 256) % 16 : v % 16;
    src  = ((f1 + f2) > 0 && ((as_v == 1 && rs_v != 3) || (as_v == 3 && rs_v == 0))) ? 1 : 0;
    dst  = (f1 == 1 && ((v / 128) % 2) == 1) ? 1 : 0;
    return 1 + src + dst;
  endfunction

  function automatic bundle_t ref_bundle(input logic [15:0] a);
    bundle_t     b;
    int          n;
    logic [15:0] a1, a2;
    a1      = a + 16'd2;
    a2      = a + 16'd4;
    n       = ref_len(rom[a]);
    b.instr = rom[a];
    b.pc    = a;
    b.nw    = 2'(n);
    b.ext1  = (n >= 2) ? rom[a1] : 16'h0000;
    b.ext2  = (n == 3) ? rom[a2] : 16'h0000;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one bundle through to acceptance, optionally stalling and/or redirecting on the accept cycle.
  task automatic run_instr(input int stall, input bit early_ready, input bit redir, input logic [15:0] tgt);
    bundle_t e;
    int      waited;
    e        = ref_bundle(model_pc);
    model_pc = model_pc + 16'(2 * int'(e.nw));
    q.push_back(e);
    bus.out_ready = early_ready && (stall == 0);
    waited = 0;
    while (!bus.out_valid && waited < 8) begin
      step();
      waited++;
    end
    if (!bus.out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: out_valid still 0 after %0d cycles, expected 1", waited);
      finish_bench();
    end
    chk("fetch_latency", waited, int'(e.nw));
    chk("hold_rom_addr", bus.rom_addr, model_pc);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_instr", bus.out_instr, e.instr);
      chk("stall_ext1", bus.out_ext1, e.ext1);
      chk("stall_pc", bus.out_pc, e.pc);
      chk("stall_rom_addr", bus.rom_addr, model_pc);
    end
    bus.out_ready = 1'b1;
    if (redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = tgt;
      model_pc           = tgt & 16'hFFFE;
    end
    step();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  // Redirect d cycles into the next fetch with decode stalled: that bundle must never appear.
  task automatic redirect_mid(input int d, input logic [15:0] tgt);
    bus.out_ready = 1'b0;
    repeat (d) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    step();
    bus.redirect_valid = 1'b0;
    model_pc = tgt & 16'hFFFE;
    chk("redirect_rom_addr", bus.rom_addr, model_pc);
  endtask

  task automatic do_reset(input bit redirect_in_vec);
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rom_addr", bus.rom_addr, 16'hFFFE);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_ext1", bus.out_ext1, 0);
    chk("rst_ext2", bus.out_ext2, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_nwords", bus.out_nwords, 0);
    q.delete();
    step();
    step();
    rst_n    = 1'b1;
    model_pc = rom[16'hFFFE] & 16'hFFFE;
    if (redirect_in_vec) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h1234;
    end
    step();
    bus.redirect_valid = 1'b0;
    chk("vec_rom_addr", bus.rom_addr, model_pc);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bundle: got instr %h at pc %h, expected no bundle", bus.out_instr, bus.out_pc);
      end else begin
        mon_e = q.pop_front();
        chk("bundle_instr", bus.out_instr, mon_e.instr);
        chk("bundle_ext1", bus.out_ext1, mon_e.ext1);
        chk("bundle_ext2", bus.out_ext2, mon_e.ext2);
        chk("bundle_pc", bus.out_pc, mon_e.pc);
        chk("bundle_nwords", bus.out_nwords, mon_e.nw);
      end
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    model_pc           = 16'h0000;
    for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
    rom[16'hFFFE] = 16'hC000;
    rom[16'hC000] = 16'h4304;
    rom[16'hC002] = 16'h40B2;
    rom[16'hC004] = 16'h1234;
    rom[16'hC006] = 16'h0200;
    rom[16'hC008] = 16'h40B2;
    rom[16'hC100] = 16'h4304;
    rom[16'h0000] = 16'h4304;
    rom[16'h0002] = 16'h40B2;

    do_reset(1'b0);
    run_instr(0, 1'b1, 1'b0, 16'h0000);    // C000: 4304, single word
    run_instr(5, 1'b0, 1'b0, 16'h0000);    // C002: 40B2 + 1234 + 0200, stalled 5 cycles
    redirect_mid(1, 16'hC101);             // hits EXT1 of the C008 bundle
    run_instr(0, 1'b0, 1'b1, 16'hFFFE);    // C100 accepted together with a redirect
    run_instr(0, 1'b1, 1'b0, 16'h0000);    // FFFE: C000 is a 1-word op, PC wraps to 0000
    run_instr(0, 1'b1, 1'b0, 16'h0000);    // 0000: 4304, next is the 3-word 40B2
    step();
    step();                                // now in EXT2 of the 0002 bundle
    do_reset(1'b1);

    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (it == 120) do_reset(1'($urandom_range(0, 1)));
      if (r == 0)      redirect_mid($urandom_range(0, 3), 16'($urandom));
      else if (r == 1) run_instr($urandom_range(0, 2), 1'b0, 1'b1, 16'($urandom));
      else             run_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                                 1'($urandom_range(0, 1)), 1'b0, 16'h0000);
    end

    step();
    step();
    chk("queue_drained", q.size(), 0);
    finish_bench();
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 16'hFFFE, meaning the ROM address holding the initial PC.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port rom_addr, output, 16, the word address to ROM.
REQ-005 The block SHALL have port BW, output, 1, the ROM byte/word select, tied 0 (word).
REQ-006 The block SHALL have port rom_out, input, 16, ROM read data, combinational from rom_addr in the same cycle.
REQ-007 The block SHALL have port out_valid, output, 1, meaning the instruction bundle is held for decode.
REQ-008 The block SHALL have port out_ready, input, 1, meaning decode accepts the bundle.
REQ-009 The block SHALL have ports out_instr, out_ext1, out_ext2, out_pc, each output, 16: opcode word, first extension word, second extension word, and opcode address.
REQ-010 The block SHALL have port out_nwords, output, 2, the bundle length in words (1..3).
REQ-011 The block SHALL have ports redirect_valid, input, 1, and redirect_pc, input, 16, the branch/jump target from execute.

Function
REQ-012 The block SHALL hold state register st in {VEC, OP, EXT1, EXT2, HOLD}, and SHALL read exactly one ROM word per cycle in VEC/OP/EXT1/EXT2.
REQ-013 VEC SHALL drive rom_addr=RESET_VECTOR, load PC<=rom_out&16'hFFFE, and go to OP.
REQ-014 OP SHALL drive rom_addr=PC, latch out_instr<=rom_out and out_pc<=PC, and set PC<=PC+2.
REQ-015 Source extension SHALL be needed iff the format is I (op[15:12]>=4) or II (op[15:10]==6'b000100), and either As==01 with Rs not 3, or As==11 with Rs==0. As=op[5:4], Rs=op[11:8] for format I and op[3:0] for format II.
REQ-016 Destination extension SHALL be needed iff the format is I and Ad (op[7]) ==1.
REQ-017 Jumps (op[15:13]==3'b001) and all other encodings SHALL have no extension words.
REQ-018 After OP, the block SHALL go to EXT1 if any extension is needed, else to HOLD; out_nwords SHALL be 1 + the number of extensions needed.
REQ-019 EXT1 SHALL read PC into out_ext1 and set PC+=2, then go to EXT2 if both extensions are needed, else to HOLD.
REQ-020 EXT2 SHALL read PC into out_ext2, set PC+=2, and go to HOLD.
REQ-021 out_ext1/out_ext2 SHALL be 16'h0000 for every slot not used by the bundle.
REQ-022 HOLD SHALL assert out_valid and keep all out_* stable until out_ready=1.
REQ-023 On an out_valid&&out_ready cycle the block SHALL go to OP next cycle, giving a minimum of 2/3/4 cycles per 1/2/3-word instruction.
REQ-024 rom_addr SHALL equal PC in HOLD, and out_valid SHALL be 0 in every state other than HOLD.
REQ-025 PC arithmetic SHALL be modulo 2^16 (16'hFFFE+2 = 16'h0000), and PC bit0 SHALL always be 0.
REQ-026 redirect_valid=1 in any state except VEC SHALL set PC<=redirect_pc&16'hFFFE, discard any partial or held bundle (out_valid low next cycle), and go to OP.
REQ-027 Redirect SHALL take priority over a simultaneous out_valid&&out_ready handshake, and the bundle SHALL count as accepted.
REQ-028 redirect_valid SHALL be ignored in VEC.

Reset
REQ-029 While rst_n=0 the block SHALL hold st=VEC, PC=16'h0000, out_valid=0, and out_instr/out_ext1/out_ext2/out_pc/out_nwords all 0.
REQ-030 Assertion of rst_n mid-instruction SHALL abort the fetch immediately, and the first cycle after deassertion SHALL be VEC.

Verification
REQ-031 Reset, ROM[FFFE]=16'hC000, ROM[C000]=16'h4304 (MOV #0,R4 via CG), out_ready=1 -> rom_addr FFFE then C000; out_valid with instr=4304, nwords=1, pc=C000.
REQ-032 ROM[C000]=16'h40B2 (MOV #imm,&abs), ext words 1234, 0200 -> bundle nwords=3, ext1=1234, ext2=0200; next OP at C006.
REQ-033 out_ready=0 for 5 cycles in HOLD -> out_valid and all outputs stable, rom_addr unchanged; accepted on the first cycle out_ready=1.
REQ-034 redirect_valid=1, redirect_pc=16'hC101 during EXT1 -> next OP reads C100; partial bundle is never presented.
REQ-035 PC=16'hFFFE with a 1-word instruction -> next OP reads 0000 (wrap).
REQ-036 rst_n pulsed low during EXT2 -> out_valid=0 immediately; refetch restarts from VEC.
